// File: rtl/antitheft_pkg.sv
// antitheft_pkg: state codes, parameter-table indices and power-on time values
package antitheft_pkg;
  typedef enum logic [2:0] {
    ARMED          = 3'd0,
    TRIGGERED      = 3'd1,
    SOUND_ALARM    = 3'd2,
    ALARM_HOLD     = 3'd3,
    DISARMED       = 3'd4,
    WAIT_DRV_OPEN  = 3'd5,
    WAIT_DRV_CLOSE = 3'd6,
    ARM_DELAY      = 3'd7
  } state_t;
  localparam logic [1:0] T_ARM_DELAY = 2'd0;
  localparam logic [1:0] T_DRIVER    = 2'd1;
  localparam logic [1:0] T_PASSENGER = 2'd2;
  localparam logic [1:0] T_ALARM_ON  = 2'd3;
  localparam int DEF_ARM_DELAY = 6;
  localparam int DEF_DRIVER    = 8;
  localparam int DEF_PASSENGER = 15;
  localparam int DEF_ALARM_ON  = 10;
  function automatic int def_value(input int idx);
    return idx == 0 ? DEF_ARM_DELAY : idx == 1 ? DEF_DRIVER : idx == 2 ? DEF_PASSENGER : DEF_ALARM_ON;
  endfunction
endpackage

// File: rtl/antitheft_timer.sv
// antitheft_timer: 1 s prescaler plus seconds countdown with a one-cycle expiry pulse
module antitheft_timer #(
  parameter int VALUE_W  = 4,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               clr,
  input  logic [VALUE_W-1:0] value,
  output logic               tick,
  output logic               expired,
  output logic [VALUE_W-1:0] count
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  assign tick = pre == PW'(TICK_DIV - 1);
  // expired fires on the edge the count reaches zero; a zero load fires right after start
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre     <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      pre <= (start || tick) ? '0 : pre + PW'(1);
      if (start) begin
        count   <= value;
        expired <= value == '0;
      end else if (clr) begin
        count   <= '0;
        expired <= 1'b0;
      end else begin
        count   <= (tick && count != '0) ? count - VALUE_W'(1) : count;
        expired <= tick && count == VALUE_W'(1);
      end
    end
  end
endmodule

// File: rtl/antitheft_alarm_ctrl.sv
// antitheft_alarm_ctrl: N-door alarm FSM with programmable time table, trip latch and event counter
module antitheft_alarm_ctrl
  import antitheft_pkg::*;
#(
  parameter int N_DOORS  = 4,
  parameter int VALUE_W  = 4,
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] door,
  input  logic               reprogram,
  input  logic [1:0]         param_sel,
  input  logic [VALUE_W-1:0] param_value,
  output logic               status,
  output logic               siren_en,
  output logic [2:0]         state,
  output logic [VALUE_W-1:0] timer_count,
  output logic [N_DOORS-1:0] trip_door,
  output logic [CNT_W-1:0]   alarm_count
);
  state_t             st;
  logic [VALUE_W-1:0] tbl [4];
  logic               t_start, t_clr, tick, expired;
  logic [1:0]         t_idx;
  assign state = st;
  always_comb begin
    t_start = 1'b0;
    t_clr   = reprogram;
    t_idx   = T_ARM_DELAY;
    if (!reprogram)
      case (st)
        ARMED: begin
          t_start = |door;
          t_idx   = door[0] ? T_DRIVER : T_PASSENGER;
        end
        TRIGGERED:      t_clr = ignition;
        SOUND_ALARM: begin
          t_start = ~|door;
          t_idx   = T_ALARM_ON;
        end
        WAIT_DRV_CLOSE: t_start = !ignition && !door[0];
        ARM_DELAY:      t_start = !ignition && |door;
        default: ;
      endcase
  end
  antitheft_timer #(.VALUE_W(VALUE_W), .TICK_DIV(TICK_DIV)) u_timer (
    .clock(clock), .reset(reset), .start(t_start), .clr(t_clr), .value(tbl[t_idx]),
    .tick(tick), .expired(expired), .count(timer_count)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) tbl[i] <= VALUE_W'(def_value(i));
      st          <= ARMED;
      status      <= 1'b0;
      siren_en    <= 1'b0;
      trip_door   <= '0;
      alarm_count <= '0;
    end else begin
      status   <= st == ARMED ? status ^ tick : (st == TRIGGERED || st == SOUND_ALARM || st == ALARM_HOLD);
      siren_en <= st == SOUND_ALARM || st == ALARM_HOLD;
      if (reprogram) begin
        tbl[param_sel] <= param_value;
        st             <= ARMED;
        trip_door      <= '0;
      end else
        case (st)
          ARMED: if (|door) begin
            st        <= TRIGGERED;
            trip_door <= door;
          end
          TRIGGERED:
            if (ignition) st <= DISARMED;
            else if (expired) begin
              st          <= SOUND_ALARM;
              alarm_count <= alarm_count + CNT_W'(alarm_count != '1);
            end
          SOUND_ALARM: if (~|door) st <= ALARM_HOLD;
          ALARM_HOLD:
            if (|door) st <= SOUND_ALARM;
            else if (expired) begin
              st        <= ARMED;
              trip_door <= '0;
            end
          DISARMED:       if (!ignition) st <= WAIT_DRV_OPEN;
          WAIT_DRV_OPEN:  st <= ignition ? DISARMED : door[0] ? WAIT_DRV_CLOSE : WAIT_DRV_OPEN;
          WAIT_DRV_CLOSE: st <= ignition ? DISARMED : !door[0] ? ARM_DELAY : WAIT_DRV_CLOSE;
          ARM_DELAY:      st <= ignition ? DISARMED : (expired && ~|door) ? ARMED : ARM_DELAY;
          default:        st <= ARMED;
        endcase
    end
  end
endmodule
